// File: rtl/encoder_pkg.sv
// Shared types and sizing helpers for the event encoder and its selector.
package encoder_pkg;

  localparam int ENC_DEFAULT_N = 8;

  typedef enum logic {
    ENC_EMPTY = 1'b0,
    ENC_HOLD  = 1'b1
  } enc_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A single request line still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational selector: highest-index priority or round-robin search
// starting just above the last granted index.
module rr_select
  import encoder_pkg::*;
#(
  parameter int N = ENC_DEFAULT_N,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] last_grant,
  input  logic         rr_mode,
  output logic [W-1:0] sel,
  output logic         sel_valid
);

  int w_best;
  int w_dist;

  // Round-robin ranks each set bit by its upward distance from last_grant+1.
  always_comb begin
    sel       = '0;
    sel_valid = |pending;
    w_best    = N;
    w_dist    = 0;
    for (int k = 0; k < N; k++) begin
      if (pending[k]) begin
        if (!rr_mode) begin
          sel = W'(k);
        end else begin
          w_dist = k - int'(last_grant) - 1;
          if (w_dist < 0) w_dist = w_dist + N;
          if (w_dist < w_best) begin
            w_best = w_dist;
            sel    = W'(k);
          end
        end
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Registered event encoder: sticky pending capture of request pulses,
// drained one binary index per cycle over a valid/ready output stage.
module event_encoder
  import encoder_pkg::*;
#(
  parameter int N = ENC_DEFAULT_N,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         rr_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         any_pending,
  output logic         overflow
);

  enc_state_t   r_state;
  logic [W-1:0] r_out_idx;
  logic [N-1:0] r_pending;
  logic [W-1:0] r_last_grant;
  logic         r_overflow;

  logic [W-1:0] w_sel;
  logic         w_sel_valid;
  logic         w_load;
  logic [N-1:0] w_load_mask;

  rr_select #(.N(N)) u_sel (
    .pending    (r_pending),
    .last_grant (r_last_grant),
    .rr_mode    (rr_mode),
    .sel        (w_sel),
    .sel_valid  (w_sel_valid)
  );

  // out_ready only matters while an index is being held.
  assign w_load = w_sel_valid && ((r_state == ENC_EMPTY) || out_ready);

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign w_load_mask[gi] = w_load && (w_sel == W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ENC_EMPTY;
      r_out_idx    <= '0;
      r_pending    <= '0;
      r_last_grant <= W'(N - 1);
      r_overflow   <= 1'b0;
    end else begin
      // A fresh request on the bit being loaded re-pends it instead of being lost.
      r_pending  <= (r_pending & ~w_load_mask) | req_in;
      r_overflow <= |(req_in & r_pending & ~w_load_mask);
      if (w_load) begin
        r_state      <= ENC_HOLD;
        r_out_idx    <= w_sel;
        r_last_grant <= w_sel;
      end else if ((r_state == ENC_HOLD) && out_ready) begin
        r_state <= ENC_EMPTY;
      end
    end
  end

  assign out_valid   = (r_state == ENC_HOLD);
  assign out_idx     = r_out_idx;
  assign pending     = r_pending;
  assign any_pending = |r_pending;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_event_encoder.sv
// Scoreboard bench: stimulus pushes expected indices, a monitor checks each accepted issue.
module tb_event_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_in;
  logic         rr_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         any_pending;
  logic         overflow;

  int n_tests;
  int n_fail;
  int sb[$];

  event_encoder #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .rr_mode     (rr_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .pending     (pending),
    .any_pending (any_pending),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: an issue is accepted when valid and ready are both high at the edge.
  always @(negedge clk) begin
    int exp_idx;
    if (!rst && out_valid && out_ready === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: got idx=%0d, required no issue", out_idx);
      end else begin
        exp_idx = sb.pop_front();
        if (int'(out_idx) !== exp_idx) begin
          n_fail++;
          $display("FAIL issue_idx: got idx=%0d, required idx=%0d", out_idx, exp_idx);
        end else begin
          $display("[TB] issue idx=%0d accepted", out_idx);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_in = '0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    check({"drain_", name}, 32'(done), 32'd1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_in    = '0;
    rr_mode   = 1'b0;
    out_ready = 1'b1;

    // Reset held with random requests
    for (int i = 0; i < 3; i++) begin
      req_in = N'($urandom_range(1, 255));
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
    end
    do_reset();

    // Fixed priority drain 7,5,1
    rr_mode = 1'b0; out_ready = 1'b1;
    req_in = 8'b1010_0010;
    sb.push_back(7); sb.push_back(5); sb.push_back(1);
    tick();
    req_in = '0;
    check("fp_pending_captured", 32'(pending), 32'hA2);
    check("fp_latency_valid", 32'(out_valid), 32'd0);
    tick();
    check("fp_first_valid", 32'(out_valid), 32'd1);
    check("fp_first_idx", 32'(out_idx), 32'd7);
    wait_drain("fixed");
    check("fp_pending_end", 32'(pending), 32'd0);
    check("fp_any_end", 32'(any_pending), 32'd0);

    // Backpressure on the first issue
    do_reset();
    out_ready = 1'b0;
    req_in = 8'b1010_0010;
    sb.push_back(7); sb.push_back(5); sb.push_back(1);
    tick();
    req_in = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx", 32'(out_idx), 32'd7);
      check("bp_pending", 32'(pending), 32'h22);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    wait_drain("backpressure");

    // Overflow while holding 7
    do_reset();
    out_ready = 1'b0;
    req_in = 8'h80;
    sb.push_back(7); sb.push_back(3);
    tick();
    req_in = '0;
    tick();
    req_in = 8'h08;
    tick();
    check("ov_pending3", 32'(pending), 32'h08);
    check("ov_first_no_pulse", 32'(overflow), 32'd0);
    tick();
    req_in = '0;
    check("ov_pulse", 32'(overflow), 32'd1);
    check("ov_hold_idx", 32'(out_idx), 32'd7);
    tick();
    check("ov_pulse_end", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    wait_drain("overflow");

    // Simultaneous load and request on the same bit
    do_reset();
    out_ready = 1'b1;
    req_in = 8'h04;
    sb.push_back(2); sb.push_back(2);
    tick();
    check("sim_pending", 32'(pending), 32'h04);
    tick();
    req_in = '0;
    check("sim_idx", 32'(out_idx), 32'd2);
    check("sim_repend", 32'(pending), 32'h04);
    check("sim_no_overflow", 32'(overflow), 32'd0);
    wait_drain("simultaneous");
    check("sim_pending_end", 32'(pending), 32'd0);

    // Round-robin with all requests held for 10 edges
    do_reset();
    rr_mode = 1'b1; out_ready = 1'b1;
    req_in = 8'hFF;
    for (int i = 0; i < 9; i++) sb.push_back(i % 8);
    for (int i = 1; i < 9; i++) sb.push_back(i % 8);
    tick();
    check("rr_no_ov_first", 32'(overflow), 32'd0);
    check("rr_pending_full", 32'(pending), 32'hFF);
    tick();
    check("rr_first_idx", 32'(out_idx), 32'd0);
    check("rr_ov_held", 32'(overflow), 32'd1);
    repeat (8) tick();
    check("rr_ov_still", 32'(overflow), 32'd1);
    req_in = '0;
    wait_drain("round_robin");
    check("rr_pending_end", 32'(pending), 32'd0);

    // Asynchronous reset in the middle of HOLD
    rr_mode = 1'b0; out_ready = 1'b0;
    req_in = 8'h81;
    tick();
    req_in = '0;
    tick();
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_idx", 32'(out_idx), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_any", 32'(any_pending), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("arst_dropped", 32'(out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
